if_id_queue: RTL and testbench

Parametrised instruction queue between the Fetcher and the Decoder, replacing the single-entry IF/ID latch. Buffers up to DEPTH fetched instructions with their PCs under a valid/ready handshake on both sides, so a decode stall no longer discards in-flight fetches. A synchronous flush empties the queue on branch redirect. An empty queue presents a bubble to the Decoder: valid 0, instruction all-zero.

---
 rtl/if_id_queue_if.sv | 28 ++
 rtl/if_id_queue.sv | 64 ++++++
 tb/tb_if_id_queue.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/if_id_queue_if.sv
// Fetcher/Decoder handshake bundle for the IF/ID instruction queue.
// master drives the fetch side and decode-side ready; slave is the queue itself.
interface if_id_queue_if #(
    parameter int INST_WIDTH = 32,
    parameter int PC_WIDTH   = 32,
    parameter int DEPTH      = 4
);
    logic                         flush;
    logic                         in_valid;
    logic                         in_ready;
    logic [INST_WIDTH-1:0]        in_inst;
    logic [PC_WIDTH-1:0]          in_pc;
    logic                         out_valid;
    logic                         out_ready;
    logic [INST_WIDTH-1:0]        out_inst;
    logic [PC_WIDTH-1:0]          out_pc;
    logic [$clog2(DEPTH+1)-1:0]   count;

    modport master (
        output flush, in_valid, in_inst, in_pc, out_ready,
        input  in_ready, out_valid, out_inst, out_pc, count
    );

    modport slave (
        input  flush, in_valid, in_inst, in_pc, out_ready,
        output in_ready, out_valid, out_inst, out_pc, count
    );
endinterface

// File: rtl/if_id_queue.sv
// DEPTH-entry FIFO of {pc, inst} between Fetcher and Decoder; one-cycle push-to-head latency, no bypass.
// in_ready depends only on occupancy (never on out_ready); flush empties it on the next edge.
module if_id_queue #(
    parameter int INST_WIDTH = 32,
    parameter int PC_WIDTH   = 32,
    parameter int DEPTH      = 4
) (
    input  logic                clk,
    input  logic                rst,
    if_id_queue_if.slave        bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int EW = PC_WIDTH + INST_WIDTH;

    logic [EW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] occ;
    logic          push;
    logic          pop;
    logic          full;
    logic          empty;
    logic [EW-1:0] head;

    assign full  = (occ == CW'(DEPTH));
    assign empty = (occ == '0);
    assign push  = bus.in_valid && !full && !bus.flush;
    assign pop   = bus.out_ready && !empty && !bus.flush;
    assign head  = mem[rd_ptr];

    assign bus.in_ready  = !full;
    assign bus.out_valid = !empty;
    assign bus.out_inst  = empty ? '0 : head[INST_WIDTH-1:0];
    assign bus.out_pc    = empty ? '0 : head[EW-1:INST_WIDTH];
    assign bus.count     = occ;

    // Storage is deliberately unreset; it is masked whenever the queue is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {bus.in_pc, bus.in_inst};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else if (bus.flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end
endmodule

// File: tb/tb_if_id_queue.sv
// Self-checking bench for if_id_queue: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_if_id_queue;
    localparam int IW = 32;
    localparam int PW = 32;
    localparam int D  = 4;

    typedef struct packed {
        logic [PW-1:0] pc;
        logic [IW-1:0] inst;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    ent_t mq[$];

    if_id_queue_if #(.INST_WIDTH(IW), .PC_WIDTH(PW), .DEPTH(D)) bus ();

    if_id_queue #(.INST_WIDTH(IW), .PC_WIDTH(PW), .DEPTH(D)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Advance one clock edge and apply the queue rules to the model.
    task automatic step();
        bit   push;
        bit   pop;
        bit   fl;
        ent_t e;
        push = bus.in_valid && (mq.size() != D) && !bus.flush;
        pop  = bus.out_ready && (mq.size() != 0) && !bus.flush;
        fl   = bus.flush;
        e    = '{pc: bus.in_pc, inst: bus.in_inst};
        @(posedge clk);
        if (rst || fl) begin
            mq.delete();
        end else begin
            if (pop)  void'(mq.pop_front());
            if (push) mq.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic offer(input logic [PW-1:0] pc);
        bus.in_valid = 1'b1;
        bus.in_pc    = pc;
        bus.in_inst  = $urandom;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.flush = 1'b0; bus.in_valid = 1'b0; bus.in_inst = '0; bus.in_pc = '0; bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        mq.delete();
        step();
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %0b want 0", bus.out_valid); end
        n_cmp++; if (bus.out_inst !== 32'h0) begin n_err++; $display("FAIL reset_out_inst: got %08h want 00000000", bus.out_inst); end
        n_cmp++; if (bus.out_pc !== 32'h0) begin n_err++; $display("FAIL reset_out_pc: got %08h want 0", bus.out_pc); end
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %0b want 1", bus.in_ready); end
        n_cmp++; if (bus.count !== 3'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", bus.count); end
    endtask

    task automatic test_fill();
        bus.out_ready = 1'b0;
        for (int i = 0; i < D; i++) begin
            offer(32'h100 + 32'(4 * i));
            step();
            n_cmp++; if (bus.count !== 3'(i + 1)) begin n_err++; $display("FAIL fill_count[%0d]: got %0d want %0d", i, bus.count, i + 1); end
        end
        n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL fill_in_ready: got %0b want 0", bus.in_ready); end
        n_cmp++; if (bus.out_pc !== 32'h100) begin n_err++; $display("FAIL fill_head_pc: got %08h want 00000100", bus.out_pc); end
        offer(32'h110);
        step();
        n_cmp++; if (bus.count !== 3'd4) begin n_err++; $display("FAIL fill_blocked_count: got %0d want 4", bus.count); end
        n_cmp++; if (bus.out_pc !== 32'h100) begin n_err++; $display("FAIL fill_blocked_head: got %08h want 00000100", bus.out_pc); end
    endtask

    // From full: pop with continuous offers; first edge from full cannot push.
    task automatic test_drain_wrap();
        logic [PW-1:0] pc;
        bit acc;
        pc = 32'h110;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            n_cmp++; if (bus.out_pc !== 32'h100 + 32'(4 * i)) begin n_err++; $display("FAIL drain_order[%0d]: got %08h want %08h", i, bus.out_pc, 32'h100 + 32'(4 * i)); end
            n_cmp++; if (bus.out_inst !== mq[0].inst) begin n_err++; $display("FAIL drain_inst[%0d]: got %08h want %08h", i, bus.out_inst, mq[0].inst); end
            acc = (mq.size() != D);
            step();
            if (acc) offer(pc + 32'd4);
            if (acc) pc = pc + 32'd4;
            n_cmp++; if (bus.count !== 3'(mq.size())) begin n_err++; $display("FAIL drain_count[%0d]: got %0d want %0d", i, bus.count, mq.size()); end
        end
        bus.in_valid = 1'b0;
        repeat (D + 1) step();
        n_cmp++; if (bus.count !== 3'd0 || bus.out_valid !== 1'b0) begin n_err++; $display("FAIL drain_empty: got count %0d valid %0b want 0/0", bus.count, bus.out_valid); end
        bus.out_ready = 1'b0;
    endtask

    task automatic test_flush();
        offer(32'h1E0); step();
        offer(32'h1E4); step();
        n_cmp++; if (bus.count !== 3'd2) begin n_err++; $display("FAIL flush_pre_count: got %0d want 2", bus.count); end
        bus.flush = 1'b1; bus.out_ready = 1'b1; offer(32'h1F0);
        step();
        bus.flush = 1'b0; bus.out_ready = 1'b0; bus.in_valid = 1'b0;
        n_cmp++; if (bus.count !== 3'd0) begin n_err++; $display("FAIL flush_count: got %0d want 0", bus.count); end
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL flush_out_valid: got %0b want 0", bus.out_valid); end
        n_cmp++; if (bus.out_inst !== 32'h0) begin n_err++; $display("FAIL flush_out_inst: got %08h want 0", bus.out_inst); end
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL flush_in_ready: got %0b want 1", bus.in_ready); end
        offer(32'h200); step(); bus.in_valid = 1'b0;
        n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h200) begin n_err++; $display("FAIL flush_next_push: got valid %0b pc %08h want 1/00000200", bus.out_valid, bus.out_pc); end
        n_cmp++; if (bus.count !== 3'd1) begin n_err++; $display("FAIL flush_next_count: got %0d want 1", bus.count); end
        bus.out_ready = 1'b1; step(); bus.out_ready = 1'b0;
    endtask

    task automatic test_pass_through();
        bus.out_ready = 1'b1;
        offer(32'h300);
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL pass_no_bypass: got valid %0b want 0", bus.out_valid); end
        step();
        bus.in_valid = 1'b0;
        n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h300) begin n_err++; $display("FAIL pass_head: got valid %0b pc %08h want 1/00000300", bus.out_valid, bus.out_pc); end
        step();
        n_cmp++; if (bus.count !== 3'd0 || bus.out_valid !== 1'b0) begin n_err++; $display("FAIL pass_drained: got count %0d valid %0b want 0/0", bus.count, bus.out_valid); end
        bus.out_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) begin
            offer(32'h400 + 32'(4 * i));
            step();
        end
        bus.in_valid = 1'b0;
        n_cmp++; if (bus.count !== 3'd3) begin n_err++; $display("FAIL areset_pre_count: got %0d want 3", bus.count); end
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL areset_out_valid: got %0b want 0", bus.out_valid); end
        n_cmp++; if (bus.count !== 3'd0) begin n_err++; $display("FAIL areset_count: got %0d want 0", bus.count); end
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL areset_in_ready: got %0b want 1", bus.in_ready); end
        n_cmp++; if (bus.out_pc !== 32'h0) begin n_err++; $display("FAIL areset_out_pc: got %08h want 0", bus.out_pc); end
        mq.delete();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_random();
        logic [PW-1:0] exp_pc;
        logic [IW-1:0] exp_inst;
        for (int c = 0; c < 400; c++) begin
            if (!(bus.in_valid && !bus.in_ready)) begin
                bus.in_valid = ($urandom_range(0, 3) != 0);
                bus.in_pc    = $urandom;
                bus.in_inst  = $urandom;
            end
            bus.out_ready = ($urandom_range(0, 2) != 0);
            bus.flush     = ($urandom_range(0, 19) == 0);
            step();
            exp_pc   = (mq.size() != 0) ? mq[0].pc : '0;
            exp_inst = (mq.size() != 0) ? mq[0].inst : '0;
            n_cmp++; if (bus.count !== 3'(mq.size())) begin n_err++; $display("FAIL rand_count[%0d]: got %0d want %0d", c, bus.count, mq.size()); end
            n_cmp++; if (bus.out_valid !== (mq.size() != 0)) begin n_err++; $display("FAIL rand_out_valid[%0d]: got %0b want %0b", c, bus.out_valid, mq.size() != 0); end
            n_cmp++; if (bus.in_ready !== (mq.size() != D)) begin n_err++; $display("FAIL rand_in_ready[%0d]: got %0b want %0b", c, bus.in_ready, mq.size() != D); end
            n_cmp++; if (bus.out_pc !== exp_pc) begin n_err++; $display("FAIL rand_out_pc[%0d]: got %08h want %08h", c, bus.out_pc, exp_pc); end
            n_cmp++; if (bus.out_inst !== exp_inst) begin n_err++; $display("FAIL rand_out_inst[%0d]: got %08h want %08h", c, bus.out_inst, exp_inst); end
        end
        bus.flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain_wrap();
        test_flush();
        test_pass_through();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
